// File: rtl/fwrisc_mem_arbiter.sv
// Shares one registered memory port between the fwrisc fetch and data interfaces.
// One transaction in flight at a time; the response is steered to the granted requester.
module fwrisc_mem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit IDLE_GAP    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic [31:0] idata,
    output logic        iready,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    input  logic [3:0]  damo,
    input  logic        dvalid,
    output logic [31:0] drdata,
    output logic        dready,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstb,
    output logic        mwrite,
    output logic [3:0]  mamo,
    output logic        mvalid,
    input  logic [31:0] mrdata,
    input  logic        mready
);

    // state   | meaning
    // IDLE    | no request outstanding, arbitrate this cycle
    // GNT_I   | fetch request on the memory port, waiting for mready
    // GNT_D   | data request on the memory port, waiting for mready
    // GAP     | one dead cycle after a completion
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  mwstb_q, mwstb_d;
    logic        mwrite_q, mwrite_d;
    logic [3:0]  mamo_q, mamo_d;
    logic        mvalid_q, mvalid_d;

    logic        arb;
    logic        req_i;
    logic        req_d;
    logic        pick_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        mwstb_d      = mwstb_q;
        mwrite_d     = mwrite_q;
        mamo_d       = mamo_q;
        mvalid_d     = mvalid_q;
        arb          = 1'b0;
        req_i        = ivalid;
        req_d        = dvalid;
        pick_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb = 1'b1;
            end
            S_GNT_I: begin
                if (mready) begin
                    mvalid_d = 1'b0;
                    if (IDLE_GAP) begin
                        state_d = S_GAP;
                    end else begin
                        // the finishing requester drops valid at this edge
                        state_d = S_IDLE;
                        arb     = 1'b1;
                        req_i   = 1'b0;
                    end
                end
            end
            S_GNT_D: begin
                if (mready) begin
                    mvalid_d = 1'b0;
                    if (IDLE_GAP) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        arb     = 1'b1;
                        req_d   = 1'b0;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arb && (req_i || req_d)) begin
            pick_d       = req_d && (!req_i || !ROUND_ROBIN || !last_grant_q);
            mvalid_d     = 1'b1;
            last_grant_d = pick_d;
            if (pick_d) begin
                state_d  = S_GNT_D;
                maddr_d  = daddr;
                mwdata_d = dwdata;
                mwstb_d  = dwstb;
                mwrite_d = dwrite;
                mamo_d   = damo;
            end else begin
                state_d  = S_GNT_I;
                maddr_d  = iaddr;
                mwdata_d = 32'h0;
                mwstb_d  = 4'hf;
                mwrite_d = 1'b0;
                mamo_d   = 4'h0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b0;
            maddr_q      <= 32'h0;
            mwdata_q     <= 32'h0;
            mwstb_q      <= 4'h0;
            mwrite_q     <= 1'b0;
            mamo_q       <= 4'h0;
            mvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            mwstb_q      <= mwstb_d;
            mwrite_q     <= mwrite_d;
            mamo_q       <= mamo_d;
            mvalid_q     <= mvalid_d;
        end
    end

    // mready outside a grant state is deliberately dropped here
    assign iready = (state_q == S_GNT_I) && mready;
    assign dready = (state_q == S_GNT_D) && mready;
    assign idata  = iready ? mrdata : 32'h0;
    assign drdata = dready ? mrdata : 32'h0;

    assign maddr  = maddr_q;
    assign mwdata = mwdata_q;
    assign mwstb  = mwstb_q;
    assign mwrite = mwrite_q;
    assign mamo   = mamo_q;
    assign mvalid = mvalid_q;

endmodule
